// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity and stop bits, timed by a baud clock enable.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the serialiser.
module uart_tx_frame #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  if (CLK_DIV < 4 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_frame: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLK_DIV - 2);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 accept, avail, take, bit_end;
  logic [DATA_BITS-1:0] next_word;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign accept  = tx_valid && ready_q;
  assign bit_end = (state_q != S_IDLE) && (baud_q == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 fifo_empty, wr, pop;

  // An empty FIFO is bypassed so a word accepted while idle starts on the same edge.
  assign fifo_empty = (wptr_q == rptr_q);
  assign avail      = accept || !fifo_empty;
  assign next_word  = fifo_empty ? tx_data : mem_q[rptr_q[AW-1:0]];
  assign pop        = take && !fifo_empty;
  assign wr         = accept && !(take && fifo_empty);

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, wr};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    ready_d = ((wptr_d - rptr_d) != DEPTH_P);
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= tx_data;
  end
`else
  assign avail     = accept;
  assign next_word = tx_data;

  // Open the handshake one clock early so a new word lands exactly on the last stop clock.
  always_comb begin
    ready_d = (state_d == S_IDLE) ||
              (state_q == S_STOP && bit_q == STOP_LAST && baud_q == BAUD_PRE);
  end
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    take    = 1'b0;
    if (state_q != S_IDLE) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    unique case (state_q)
      S_IDLE: if (avail) take = 1'b1;
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_d   = 4'd0;
            tx_d    = (PARITY != 0) ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            if (avail) begin
              take = 1'b1;
            end else begin
              state_d = S_IDLE;
              bit_d   = 4'd0;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d = S_START;
      baud_d  = 16'd0;
      bit_d   = 4'd0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      shift_d = next_word;
      par_d   = parity_of(next_word);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 4'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_FIFO_EN
      wptr_q  <= '0;
      rptr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_FIFO_EN
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
`endif
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1 and 7O2 instances at CLK_DIV = 4, with FIFO checks when UART_TX_FIFO_EN is set.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0, ready0, tx0, busy0;
  logic [7:0] data0;
  logic       valid1, ready1, tx1, busy1;
  logic [6:0] data1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q0[$];
  logic       pend0;
  logic       rdy_log [0:1023];
  logic [10:0] exp1;

`ifdef UART_TX_FIFO_EN
  localparam logic RDY_MID = 1'b1;
`else
  localparam logic RDY_MID = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_valid(valid0), .tx_data(data0),
    .tx_ready(ready0), .tx(tx0), .tx_busy(busy0));

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .tx_valid(valid1), .tx_data(data1),
    .tx_ready(ready1), .tx(tx1), .tx_busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at each falling edge: retire the word taken on the previous rising edge, present the next.
  task automatic tick_u0(output logic committed);
    logic [7:0] dummy;
    committed = pend0;
    if (pend0) dummy = q0.pop_front();
    if (q0.size() > 0) begin
      valid0 = 1'b1;
      data0  = ready0 ? q0[0] : 8'($urandom);
    end else begin
      valid0 = 1'b0;
      data0  = 8'($urandom);
    end
    pend0 = valid0 && ready0;
  endtask

  task automatic run_u0(input string tag);
    logic exp_q[$];
    int   k = 0;
    int   total;
    logic started = 1'b0;
    logic com;
    foreach (q0[i]) begin
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(q0[i][b]);
      exp_q.push_back(1'b1);
    end
    total = exp_q.size() * 4;
    pend0 = 1'b0;
    for (int cyc = 0; cyc < total + 50 && k <= total; cyc++) begin
      @(negedge clk);
      tick_u0(com);
      if (com) started = 1'b1;
      if (started) begin
        if (k < 1024) rdy_log[k] = ready0;
        if (k < total) begin
          chk({tag, "_tx"}, 32'(tx0), 32'(exp_q[k / 4]));
          chk({tag, "_busy"}, 32'(busy0), 32'd1);
        end else begin
          chk({tag, "_idle_tx"}, 32'(tx0), 32'd1);
          chk({tag, "_idle_busy"}, 32'(busy0), 32'd0);
        end
        k++;
      end
    end
    chk({tag, "_complete"}, 32'(k > total), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid0 = 1'b0; data0 = 8'h00; valid1 = 1'b0; data1 = 7'h00; pend0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_ready0_low", 32'(ready0), 32'd0);
    @(negedge clk);
    chk("release_ready0_high", 32'(ready0), 32'd1);
    chk("release_ready1_high", 32'(ready1), 32'd1);

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1 for 4 clocks each
    q0 = {8'hA5};
    run_u0("a5");
    chk("a5_ready_k38", 32'(rdy_log[38]), 32'(RDY_MID));
    chk("a5_ready_k39", 32'(rdy_log[39]), 32'd1);
    chk("a5_ready_idle", 32'(rdy_log[40]), 32'd1);

    // Back-to-back: second start bit directly follows the first stop bit
    q0 = {8'h00, 8'hFF};
    run_u0("b2b");
    chk("b2b_ready_after_accept", 32'(rdy_log[40]), 32'(RDY_MID));

    // 7O2, 0x03: 0, 1,1,0,0,0,0,0, parity 1, 1, 1
    exp1 = 11'b11100000110;
    @(negedge clk);
    valid1 = 1'b1; data1 = 7'h03;
    @(negedge clk);
    valid1 = 1'b0; data1 = 7'h7F;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      chk("o2_tx", 32'(tx1), 32'(exp1[k / 4]));
      chk("o2_busy", 32'(busy1), 32'd1);
      if (k == 42) chk("o2_ready_k42", 32'(ready1), 32'(RDY_MID));
      if (k == 43) chk("o2_ready_k43", 32'(ready1), 32'd1);
    end
    @(negedge clk);
    chk("o2_end_busy", 32'(busy1), 32'd0);
    chk("o2_end_tx", 32'(tx1), 32'd1);

    // Reset in the middle of a frame
    @(negedge clk);
    valid0 = 1'b1; data0 = 8'h5A;
    @(negedge clk);
    valid0 = 1'b0;
    chk("mf_start_tx", 32'(tx0), 32'd0);
    chk("mf_start_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mf_rst_tx", 32'(tx0), 32'd1);
    chk("mf_rst_busy", 32'(busy0), 32'd0);
    chk("mf_rst_ready", 32'(ready0), 32'd0);
    chk("mf_rst_ready1", 32'(ready1), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("mf_hold_tx", 32'(tx0), 32'd1);
      chk("mf_hold_ready", 32'(ready0), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mf_release_ready", 32'(ready0), 32'd1);
    repeat (12) begin
      @(negedge clk);
      chk("mf_after_tx", 32'(tx0), 32'd1);
      chk("mf_after_busy", 32'(busy0), 32'd0);
    end

`ifdef UART_TX_FIFO_EN
    // 20 words at full rate through the 4-entry FIFO
    q0 = {8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h0F, 8'hF0,
          8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h7E, 8'h81};
    run_u0("fifo20");
    chk("fifo_ready_k3", 32'(rdy_log[3]), 32'd1);
    for (int k = 4; k < 40; k++) chk("fifo_full_ready", 32'(rdy_log[k]), 32'd0);
    chk("fifo_ready_after_pop", 32'(rdy_log[40]), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
